// File: rtl/lc3_mmio_ctrl_if.sv
// Bus between the LC-3 control FSM/datapath/devices and the MMIO access controller.
// The controller takes the slave modport; the CPU side and the devices take master.
interface lc3_mmio_ctrl_if;
  logic        i_MIO_EN;
  logic        i_RW;
  logic [15:0] i_MAR;
  logic [15:0] i_MDR;
  logic        o_MEM_EN;
  logic [1:0]  o_INMUX_SEL;
  logic        o_R;
  logic        o_LD_KBSR;
  logic        o_LD_DSR;
  logic        o_LD_DDR;
  logic [15:0] o_KBSR;
  logic [15:0] o_KBDR;
  logic [15:0] o_DSR;
  logic        i_Kbd_Valid;
  logic [7:0]  i_Kbd_Data;
  logic        o_Kbd_Ready;
  logic        o_Disp_Valid;
  logic [7:0]  o_Disp_Data;
  logic        i_Disp_Ready;
  logic        o_Kbd_Int;

  modport master (
    output i_MIO_EN, i_RW, i_MAR, i_MDR, i_Kbd_Valid, i_Kbd_Data, i_Disp_Ready,
    input  o_MEM_EN, o_INMUX_SEL, o_R, o_LD_KBSR, o_LD_DSR, o_LD_DDR, o_KBSR, o_KBDR, o_DSR,
    input  o_Kbd_Ready, o_Disp_Valid, o_Disp_Data, o_Kbd_Int
  );

  modport slave (
    input  i_MIO_EN, i_RW, i_MAR, i_MDR, i_Kbd_Valid, i_Kbd_Data, i_Disp_Ready,
    output o_MEM_EN, o_INMUX_SEL, o_R, o_LD_KBSR, o_LD_DSR, o_LD_DDR, o_KBSR, o_KBDR, o_DSR,
    output o_Kbd_Ready, o_Disp_Valid, o_Disp_Data, o_Kbd_Int
  );
endinterface

// File: rtl/lc3_mmio_ctrl.sv
// LC-3 memory/IO access controller: address decode, memory wait-state sequencing of R,
// and the keyboard (KBSR/KBDR) and display (DSR/DDR) device handshakes.
module lc3_mmio_ctrl #(
  parameter int unsigned MEM_WAIT = 3
) (
  input logic             i_Clk,
  input logic             i_Rst_n,
  lc3_mmio_ctrl_if.slave  bus
);

  localparam logic [3:0] WaitLoad = 4'(MEM_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StRelease} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        kb_full_q, kb_full_d, kb_ie_q, kb_ie_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        dsr_rdy_q, dsr_rdy_d, dsr_ie_q, dsr_ie_d;
  logic        disp_valid_q, disp_valid_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic        kbsr_chg_q, kbsr_chg_d, dsr_chg_q, dsr_chg_d;
  logic        ld_kbsr_q, ld_dsr_q;

  logic is_dev, sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
  logic commit_wr, commit_rd, kbd_xfer, disp_xfer;
  logic unused_mdr;

  assign is_dev    = bus.i_MAR >= 16'hFE00;
  assign sel_kbsr  = bus.i_MAR == 16'hFE00;
  assign sel_kbdr  = bus.i_MAR == 16'hFE02;
  assign sel_dsr   = bus.i_MAR == 16'hFE04;
  assign sel_ddr   = bus.i_MAR == 16'hFE06;
  assign commit_wr = (state_q == StDone) & bus.i_RW;
  assign commit_rd = (state_q == StDone) & ~bus.i_RW;
  assign kbd_xfer  = bus.i_Kbd_Valid & ~kb_full_q;
  assign disp_xfer = disp_valid_q & bus.i_Disp_Ready;
  assign unused_mdr = ^{bus.i_MDR[15], bus.i_MDR[13:8]};

  // Access sequencing; an aborted BUSY returns to IDLE with no R and no side effects.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_MIO_EN) begin
          if (is_dev || MEM_WAIT <= 1) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = WaitLoad;
          end
        end
      end
      StBusy: begin
        if (!bus.i_MIO_EN) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = StDone;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:    state_d = StRelease;
      StRelease: if (!bus.i_MIO_EN) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Device registers; a DDR write on the same edge as a display handshake wins.
  always_comb begin
    kb_full_d    = kb_full_q;
    kb_ie_d      = kb_ie_q;
    kbdr_d       = kbdr_q;
    dsr_rdy_d    = dsr_rdy_q;
    dsr_ie_d     = dsr_ie_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    if (commit_rd && sel_kbdr) kb_full_d = 1'b0;
    if (commit_wr && sel_kbsr) kb_ie_d = bus.i_MDR[14];
    if (kbd_xfer) begin
      kbdr_d    = bus.i_Kbd_Data;
      kb_full_d = 1'b1;
    end
    if (commit_wr && sel_dsr) dsr_ie_d = bus.i_MDR[14];
    if (disp_xfer) begin
      disp_valid_d = 1'b0;
      dsr_rdy_d    = 1'b1;
    end
    if (commit_wr && sel_ddr) begin
      disp_data_d  = bus.i_MDR[7:0];
      disp_valid_d = 1'b1;
      dsr_rdy_d    = 1'b0;
    end
    kbsr_chg_d = (kb_full_d != kb_full_q) | (kb_ie_d != kb_ie_q);
    dsr_chg_d  = (dsr_rdy_d != dsr_rdy_q) | (dsr_ie_d != dsr_ie_q);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      kb_full_q    <= 1'b0;
      kb_ie_q      <= 1'b0;
      kbdr_q       <= 8'h00;
      dsr_rdy_q    <= 1'b1;
      dsr_ie_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
      kbsr_chg_q   <= 1'b0;
      dsr_chg_q    <= 1'b0;
      ld_kbsr_q    <= 1'b0;
      ld_dsr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kb_full_q    <= kb_full_d;
      kb_ie_q      <= kb_ie_d;
      kbdr_q       <= kbdr_d;
      dsr_rdy_q    <= dsr_rdy_d;
      dsr_ie_q     <= dsr_ie_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      kbsr_chg_q   <= kbsr_chg_d;
      dsr_chg_q    <= dsr_chg_d;
      // Strobe trails the visible register change by one cycle.
      ld_kbsr_q    <= kbsr_chg_q;
      ld_dsr_q     <= dsr_chg_q;
    end
  end

  always_comb begin
    bus.o_INMUX_SEL = 2'b00;
    if (sel_kbsr)      bus.o_INMUX_SEL = 2'b01;
    else if (sel_kbdr) bus.o_INMUX_SEL = 2'b10;
    else if (sel_dsr)  bus.o_INMUX_SEL = 2'b11;
  end

  assign bus.o_MEM_EN     = bus.i_MIO_EN & ~is_dev;
  assign bus.o_R          = state_q == StDone;
  assign bus.o_LD_DDR     = commit_wr & sel_ddr;
  assign bus.o_LD_KBSR    = ld_kbsr_q;
  assign bus.o_LD_DSR     = ld_dsr_q;
  assign bus.o_KBSR       = {kb_full_q, kb_ie_q, 14'h0000};
  assign bus.o_KBDR       = {8'h00, kbdr_q};
  assign bus.o_DSR        = {dsr_rdy_q, dsr_ie_q, 14'h0000};
  assign bus.o_Kbd_Ready  = ~kb_full_q;
  assign bus.o_Kbd_Int    = kb_full_q & kb_ie_q;
  assign bus.o_Disp_Valid = disp_valid_q;
  assign bus.o_Disp_Data  = disp_data_q;

endmodule

// File: doc/lc3_mmio_ctrl.md
# lc3_mmio_ctrl

Memory/I-O access controller for the LC-3 core. Sits between the FSM's memory-control outputs (MIO_EN, RW) and the datapath's memory and device registers. Decodes MAR into memory versus device space, generates MEM_EN, INMUX_SEL and the device load strobes, and inserts memory wait states by sequencing the R ready handshake. Owns the keyboard (KBSR/KBDR) and display (DSR/DDR) status handshakes with the external devices.

## Interface
- MEM_WAIT, 3, memory access latency in cycles, legal 1..15
- i_Clk  in  1  system clock, rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_MIO_EN  in  1  FSM requests a memory/IO access; held until R seen
- i_RW  in  1  1 = write, 0 = read
- i_MAR  in  16  access address
- i_MDR  in  16  write data (device writes)
- o_MEM_EN  out  1  memory array enable
- o_INMUX_SEL  out  2  read source: 00 memory, 01 KBSR, 10 KBDR, 11 DSR
- o_R  out  1  access complete, one-cycle pulse
- o_LD_KBSR, o_LD_DSR, o_LD_DDR  out  1 each  datapath device-register load strobes
- o_KBSR, o_KBDR, o_DSR  out  16 each  device register values to datapath inputs
- i_Kbd_Valid  in  1  keyboard has a character
- i_Kbd_Data  in  8  keyboard character
- o_Kbd_Ready  out  1  controller accepts a character
- o_Disp_Valid  out  1  display character pending
- o_Disp_Data  out  8  display character
- i_Disp_Ready  in  1  display accepts character
- o_Kbd_Int  out  1  KBSR[15] & KBSR[14]

## Operation
- Address decode: device space = MAR >= 0xFE00. KBSR 0xFE00, KBDR 0xFE02, DSR 0xFE04, DDR 0xFE06; other device addresses read 0x0000 (INMUX 00 with MEM_EN 0) and ignore writes.
- o_MEM_EN = i_MIO_EN & ~device (combinational). o_INMUX_SEL combinational from MAR per encoding; DDR and unmapped → 00.
- FSM states: IDLE, BUSY, DONE, RELEASE.
  - IDLE: i_MIO_EN=1 → memory: load counter MEM_WAIT-1, go BUSY (or DONE if MEM_WAIT=1); device → DONE.
  - BUSY: decrement; at 0 → DONE. i_MIO_EN=0 → IDLE (abort, no R, no side effects).
  - DONE: o_R=1 for this cycle only; side effects commit at this edge; → RELEASE.
  - RELEASE: wait for i_MIO_EN=0 → IDLE. Back-to-back accesses require one low cycle of MIO_EN.
- Device side effects (in DONE only):
  - Read KBDR: KBSR[15] ← 0.
  - Write KBSR / DSR: bit 14 ← i_MDR[14]; other bits unchanged.
  - Write DDR: o_Disp_Data ← i_MDR[7:0], o_Disp_Valid ← 1, DSR[15] ← 0, o_LD_DDR=1 this cycle. Writing while valid overwrites data; valid stays 1.
- Keyboard: o_Kbd_Ready = ~KBSR[15]. Transfer on i_Kbd_Valid & o_Kbd_Ready: KBDR ← {8'h00, data}, KBSR[15] ← 1.
- Display: transfer on o_Disp_Valid & i_Disp_Ready: o_Disp_Valid ← 0, DSR[15] ← 1. Same-edge DDR write wins: valid stays 1, DSR[15]=0, new data.
- o_LD_KBSR / o_LD_DSR: registered, high one cycle after any change of o_KBSR / o_DSR so the datapath samples the new value.
- Bits 13:0 of KBSR/DSR always 0.

## Timing
- Reset (async, any state): FSM IDLE, o_R 0, counter 0, KBSR 0x0000, KBDR 0x0000, DSR 0x8000, o_Disp_Valid 0, o_Disp_Data 0x00, all LD strobes 0. Reset mid-access drops the access; the FSM must reissue.
- Memory latency: MIO_EN sampled high at edge 0 → o_R high during cycle MEM_WAIT (after edge MEM_WAIT), for exactly one cycle.
- Device latency: o_R high during cycle 1.
- o_Kbd_Ready drops the cycle after a keyboard transfer; re-asserts the cycle after the KBDR read completes.
- Device state changes visible on o_KBSR/o_DSR one cycle after the causing edge; LD strobes follow one cycle later.

## Test plan
- Reset mid-BUSY with MEM_WAIT=3: deassert i_Rst_n → o_R 0, DSR 0x8000, KBSR 0; next read completes in full 3 cycles.
- Memory read 0x3000, MEM_WAIT=3: MEM_EN=1, INMUX 00, o_R one pulse exactly 3 cycles after MIO_EN; no second pulse while MIO_EN held.
- Keyboard: Kbd_Valid with 0x41 → KBSR 0x8000, KBDR 0x0041, Kbd_Ready 0, LD_KBSR pulse; CPU read 0xFE02 → R in 1 cycle, INMUX 10, KBSR 0x0000, Ready 1.
- Display: write 0xFE06 data 0x0058 → Disp_Valid 1, Disp_Data 0x58, DSR 0x0000, LD_DDR pulse; Disp_Ready → Valid 0, DSR 0x8000.
- Collision: DDR write on same edge as Disp_Ready handshake → Valid stays 1, new data, DSR 0x0000.
- Abort: MIO_EN drops in BUSY → no R, FSM IDLE; write 0xFE00 with MDR 0x4000 then keyboard char → KBSR 0xC000, o_Kbd_Int 1.
